// File: rtl/stream_join_pkg.sv
// Shared types and helpers for the registered stream join.
package stream_join_pkg;

    // Per-lane occupancy state.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    // Total width of the packed lane bus.
    function automatic int unsigned join_width(input int unsigned n_inp,
                                               input int unsigned data_width);
        return n_inp * data_width;
    endfunction

endpackage

// File: rtl/stream_join_lane.sv
// One lane of the stream join: occupancy FSM plus word register.
// Optional feature: STREAM_JOIN_REG_BYPASS_EN lets a FULL lane reload in the
// same edge as the joined-word handshake.
module stream_join_lane
    import stream_join_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  join_hs,
    output logic                  full,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] data_q
);

    lane_state_t           state_q;
    lane_state_t           state_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  capture;

    // Ready, capture strobe and next-state/data selection.
    always_comb begin
        ready   = 1'b0;
        state_d = state_q;
        data_d  = data_q;
        // Upstream never sees ready while reset is held.
        if (!rst) begin
`ifdef STREAM_JOIN_REG_BYPASS_EN
            ready = (state_q == EMPTY) || join_hs;
`else
            ready = (state_q == EMPTY);
`endif
        end
        capture = valid && ready;
        if (capture) begin
            data_d = data;
        end
        case (state_q)
            EMPTY: begin
                if (capture) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                // A capture coinciding with the join handshake is a reload.
                if (join_hs && !capture) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        full = (state_q == FULL);
    end

    // Lane state and word register, synchronously cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/stream_join_reg.sv
// Registered N-way stream join: each lane captures one word, the concatenated
// word is offered downstream once every lane is full.
// Optional feature: STREAM_JOIN_REG_BYPASS_EN (full-throughput reload, adds a
// combinational ready_i -> ready_o path).
module stream_join_reg
    import stream_join_pkg::*;
#(
    parameter int unsigned N_INP      = 2,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [N_INP-1:0]                          valid_i,
    output logic [N_INP-1:0]                          ready_o,
    input  logic [join_width(N_INP, DATA_WIDTH)-1:0]  data_i,
    output logic                                      valid_o,
    input  logic                                      ready_i,
    output logic [join_width(N_INP, DATA_WIDTH)-1:0]  data_o
);

    if (N_INP < 1) begin : g_n_inp_check
        $error("stream_join_reg: N_INP must be at least 1");
    end

    logic [N_INP-1:0] lane_full;
    logic             join_hs;

    // Joined word is valid only when every lane holds data; masked in reset so
    // no output handshake can happen while state is being discarded.
    always_comb begin
        valid_o = (&lane_full) && !rst_i;
        join_hs = valid_o && ready_i;
    end

    for (genvar i = 0; i < N_INP; i++) begin : g_lane
        stream_join_lane #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk     (clk_i),
            .rst     (rst_i),
            .valid   (valid_i[i]),
            .data    (data_i[i*DATA_WIDTH +: DATA_WIDTH]),
            .join_hs (join_hs),
            .full    (lane_full[i]),
            .ready   (ready_o[i]),
            .data_q  (data_o[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_stream_join_reg.sv
// Directed, table-driven bench for stream_join_reg (3 lanes x 8 bits).
module tb_stream_join_reg;

    localparam int unsigned N  = 3;
    localparam int unsigned W  = 8;
    localparam int unsigned DW = N * W;
`ifdef STREAM_JOIN_REG_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i;
    logic [N-1:0]  valid_i;
    logic [N-1:0]  ready_o;
    logic [DW-1:0] data_i;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] data_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_join_reg #(
        .N_INP      (N),
        .DATA_WIDTH (W)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    typedef struct {
        logic          rst;
        logic [N-1:0]  valid;
        logic [DW-1:0] data;
        logic          rdy;
        logic          exp_valid;
        logic [N-1:0]  exp_ready;
        logic          chk_data;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then let outputs settle.
    task automatic step(input logic r, input logic [N-1:0] v, input logic [DW-1:0] d,
                        input logic rdy);
        @(negedge clk);
        rst_i   = r;
        valid_i = v;
        data_i  = d;
        ready_i = rdy;
        #1;
    endtask

    function automatic logic [DW-1:0] stream_word(input int m);
        logic [5:0] c;
        c = 6'(m);
        return {2'd2, c, 2'd1, c, 2'd0, c};
    endfunction

    initial begin
        logic [N-1:0] exp_r;
        logic [5:0]   cnt[N];
        int           words;
        int           exp_words;

        rst_i   = 1'b1;
        valid_i = '1;
        data_i  = '1;
        ready_i = 1'b0;

        // rst valid data rdy | exp_valid exp_ready chk_data exp_data
        vecs[0]  = '{1'b1, 3'b111, 24'hFFFFFF, 1'b0, 1'b0, 3'b000, 1'b0, 24'h000000};
        vecs[1]  = '{1'b1, 3'b111, 24'hFFFFFF, 1'b0, 1'b0, 3'b000, 1'b1, 24'h000000};
        vecs[2]  = '{1'b0, 3'b000, 24'h000000, 1'b0, 1'b0, 3'b111, 1'b1, 24'h000000};
        vecs[3]  = '{1'b0, 3'b001, 24'h0000A1, 1'b0, 1'b0, 3'b111, 1'b1, 24'h000000};
        vecs[4]  = '{1'b0, 3'b000, 24'h000000, 1'b0, 1'b0, 3'b110, 1'b1, 24'h0000A1};
        vecs[5]  = '{1'b0, 3'b100, 24'hC30000, 1'b0, 1'b0, 3'b110, 1'b1, 24'h0000A1};
        vecs[6]  = '{1'b0, 3'b000, 24'h000000, 1'b0, 1'b0, 3'b010, 1'b1, 24'hC300A1};
        vecs[7]  = '{1'b0, 3'b010, 24'h00B200, 1'b0, 1'b0, 3'b010, 1'b1, 24'hC300A1};
        vecs[8]  = '{1'b0, 3'b000, 24'h000000, 1'b0, 1'b1, 3'b000, 1'b1, 24'hC3B2A1};
        for (int k = 9; k < 19; k++) begin
            vecs[k] = '{1'b0, 3'b111, (k % 2 == 1) ? 24'h55AA33 : 24'hAA55CC, 1'b0,
                        1'b1, 3'b000, 1'b1, 24'hC3B2A1};
        end
        vecs[19] = '{1'b0, 3'b000, 24'h000000, 1'b1, 1'b1, 3'b000, 1'b1, 24'hC3B2A1};
        vecs[20] = '{1'b0, 3'b000, 24'h000000, 1'b0, 1'b0, 3'b111, 1'b1, 24'hC3B2A1};

        // Reset, staggered lanes, backpressure hold, output handshake.
        for (int k = 0; k < 21; k++) begin
            step(vecs[k].rst, vecs[k].valid, vecs[k].data, vecs[k].rdy);
            exp_r = vecs[k].exp_ready;
            if (Bypass && vecs[k].exp_valid && vecs[k].rdy) begin
                exp_r = '1;
            end
            check($sformatf("vec%0d valid_o", k), DW'(valid_o), DW'(vecs[k].exp_valid));
            check($sformatf("vec%0d ready_o", k), DW'(ready_o), DW'(exp_r));
            if (vecs[k].chk_data) begin
                check($sformatf("vec%0d data_o", k), data_o, vecs[k].exp_data);
            end
        end

        // Continuous streaming: upstream holds each lane's word until accepted.
        for (int i = 0; i < N; i++) cnt[i] = '0;
        words     = 0;
        exp_words = Bypass ? 20 : 10;
        for (int c = 0; c < 22; c++) begin
            if (c < 20) begin
                step(1'b0, 3'b111, {2'd2, cnt[2], 2'd1, cnt[1], 2'd0, cnt[0]}, 1'b1);
            end else begin
                step(1'b0, 3'b000, 24'h000000, 1'b1);
            end
            if (valid_o && ready_i) begin
                check($sformatf("stream word %0d", words), data_o, stream_word(words));
                words++;
            end
            for (int i = 0; i < N; i++) begin
                if (valid_i[i] && ready_o[i]) cnt[i]++;
            end
        end
        check("stream word count", DW'(words), DW'(exp_words));

        // Mid-join reset: two lanes loaded, reset, then only fresh data joins.
        step(1'b0, 3'b011, 24'h002211, 1'b0);
        check("midrst load ready_o", DW'(ready_o), 24'h000007);
        step(1'b0, 3'b000, 24'h000000, 1'b0);
        check("midrst partial ready_o", DW'(ready_o), 24'h000004);
        check("midrst partial valid_o", DW'(valid_o), 24'h0);
        step(1'b1, 3'b000, 24'h000000, 1'b0);
        check("midrst in-reset ready_o", DW'(ready_o), 24'h0);
        check("midrst in-reset valid_o", DW'(valid_o), 24'h0);
        step(1'b0, 3'b000, 24'h000000, 1'b0);
        check("midrst post ready_o", DW'(ready_o), 24'h000007);
        check("midrst post data_o", data_o, 24'h000000);
        check("midrst post valid_o", DW'(valid_o), 24'h0);
        step(1'b0, 3'b100, 24'h330000, 1'b0);
        step(1'b0, 3'b000, 24'h000000, 1'b0);
        check("midrst lane2 only valid_o", DW'(valid_o), 24'h0);
        check("midrst lane2 only ready_o", DW'(ready_o), 24'h000003);
        step(1'b0, 3'b011, 24'h005544, 1'b0);
        step(1'b0, 3'b000, 24'h000000, 1'b0);
        check("midrst joined valid_o", DW'(valid_o), 24'h1);
        check("midrst joined data_o", data_o, 24'h335544);
        step(1'b0, 3'b000, 24'h000000, 1'b1);
        step(1'b0, 3'b000, 24'h000000, 1'b0);
        check("midrst drained valid_o", DW'(valid_o), 24'h0);
        check("midrst drained ready_o", DW'(ready_o), 24'h000007);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
